// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the single-port memory.
// The arbiter takes the master modport; the masters and memory sit on the slave side.
interface mem_arbiter_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic       dma_req;
  logic       dma_we;
  logic [7:0] dma_addr;
  logic [7:0] dma_wdata;
  logic       dma_ack;
  logic [7:0] rdata;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_ack, dma_ack, rdata,
    output mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_ack, dma_ack, rdata,
    input  mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the single-port 256x8 memory: CPU has priority, but a
// bounded run counter forces a DMA slot after MAX_CPU_RUN contended CPU grants.
module mem_arbiter #(
  parameter int unsigned MAX_CPU_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_CPU_RUN);

  state_t     state_r, state_n;
  logic [3:0] run_cnt_r, run_cnt_n;
  logic       we_r, we_n;
  logic [7:0] addr_r, addr_n;
  logic [7:0] wdata_r, wdata_n;
  logic       owner_r, owner_n;
  logic       busy_r, busy_n;
  logic       mem_we_r, mem_we_n;
  logic       cpu_ack_r, cpu_ack_n;
  logic       dma_ack_r, dma_ack_n;
  logic [7:0] rdata_hold_r, rdata_hold_n;
  logic [7:0] rdata_s;

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      run_cnt_r    <= 4'd0;
      we_r         <= 1'b0;
      addr_r       <= 8'd0;
      wdata_r      <= 8'd0;
      owner_r      <= 1'b0;
      busy_r       <= 1'b0;
      mem_we_r     <= 1'b0;
      cpu_ack_r    <= 1'b0;
      dma_ack_r    <= 1'b0;
      rdata_hold_r <= 8'd0;
    end else begin
      state_r      <= state_n;
      run_cnt_r    <= run_cnt_n;
      we_r         <= we_n;
      addr_r       <= addr_n;
      wdata_r      <= wdata_n;
      owner_r      <= owner_n;
      busy_r       <= busy_n;
      mem_we_r     <= mem_we_n;
      cpu_ack_r    <= cpu_ack_n;
      dma_ack_r    <= dma_ack_n;
      rdata_hold_r <= rdata_hold_n;
    end
  end

  // Memory data only arrives during RESP, so the response path bypasses the hold register
  always_comb begin
    if (state_r == RESP) begin
      rdata_s = we_r ? wdata_r : bus.mem_rdata;
    end else begin
      rdata_s = rdata_hold_r;
    end
  end

  // Arbitration, next-state and next-output logic
  always_comb begin
    state_n      = state_r;
    run_cnt_n    = run_cnt_r;
    we_n         = we_r;
    addr_n       = addr_r;
    wdata_n      = wdata_r;
    owner_n      = owner_r;
    mem_we_n     = 1'b0;
    cpu_ack_n    = 1'b0;
    dma_ack_n    = 1'b0;
    rdata_hold_n = rdata_hold_r;

    case (state_r)
      IDLE: begin
        if (bus.cpu_req && bus.dma_req) begin
          state_n = ACCESS;
          // Counter never exceeds the limit: reaching it hands the slot to DMA and clears it
          if (run_cnt_r >= RUN_LIMIT) begin
            owner_n   = 1'b1;
            run_cnt_n = 4'd0;
            we_n      = bus.dma_we;
            addr_n    = bus.dma_addr;
            wdata_n   = bus.dma_wdata;
          end else begin
            owner_n   = 1'b0;
            run_cnt_n = run_cnt_r + 4'd1;
            we_n      = bus.cpu_we;
            addr_n    = bus.cpu_addr;
            wdata_n   = bus.cpu_wdata;
          end
        end else if (bus.cpu_req) begin
          state_n   = ACCESS;
          owner_n   = 1'b0;
          run_cnt_n = 4'd0;
          we_n      = bus.cpu_we;
          addr_n    = bus.cpu_addr;
          wdata_n   = bus.cpu_wdata;
        end else if (bus.dma_req) begin
          state_n   = ACCESS;
          owner_n   = 1'b1;
          run_cnt_n = 4'd0;
          we_n      = bus.dma_we;
          addr_n    = bus.dma_addr;
          wdata_n   = bus.dma_wdata;
        end else begin
          state_n = IDLE;
        end
        mem_we_n = (state_n == ACCESS) ? we_n : 1'b0;
      end
      ACCESS: begin
        state_n   = RESP;
        cpu_ack_n = ~owner_r;
        dma_ack_n = owner_r;
      end
      RESP: begin
        state_n      = IDLE;
        rdata_hold_n = rdata_s;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dma_ack   = dma_ack_r;
  assign bus.rdata     = rdata_s;
  assign busy          = busy_r;
  assign owner         = owner_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model predicts every cycle,
// and literal expectations pin read data, grant order and reset behaviour.
module tb_mem_arbiter;
  localparam int unsigned MAX_RUN = 4;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic owner;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_CPU_RUN(MAX_RUN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master),
    .busy  (busy),
    .owner (owner)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Synchronous memory: read data appears one edge after the address
  logic [7:0] mem [256];
  always @(posedge clk) begin
    logic [7:0] rd;
    rd = mem[bus.mem_addr];
    if (bus.mem_we === 1'b1) mem[bus.mem_addr] = bus.mem_wdata;
    bus.mem_rdata <= rd;
  end

  // Transaction-level model: a grant at edge g occupies edges g..g+2, next sample at g+3
  logic [7:0]  shadow [256];
  int unsigned ec      = 0;
  int unsigned next_ok = 0;
  int unsigned cnt     = 0;
  bit          have_txn = 1'b0;
  int unsigned t_g     = 0;
  bit          t_dma, t_we;
  logic [7:0]  t_addr, t_wdata, t_rdata;
  bit          e_owner = 1'b0;
  bit          rst_now = 1'b0;

  always @(posedge clk) begin
    bit pick_dma;
    ec = ec + 1;
    rst_now = (reset === 1'b1);
    if (rst_now) begin
      have_txn = 1'b0;
      cnt      = 0;
      e_owner  = 1'b0;
      next_ok  = ec + 1;
    end else if (ec >= next_ok && (bus.cpu_req || bus.dma_req)) begin
      pick_dma = bus.dma_req && (!bus.cpu_req || cnt >= MAX_RUN);
      if (bus.cpu_req && bus.dma_req && !pick_dma) cnt = cnt + 1;
      else cnt = 0;
      have_txn = 1'b1;
      t_g      = ec;
      t_dma    = pick_dma;
      t_we     = pick_dma ? bus.dma_we    : bus.cpu_we;
      t_addr   = pick_dma ? bus.dma_addr  : bus.cpu_addr;
      t_wdata  = pick_dma ? bus.dma_wdata : bus.cpu_wdata;
      t_rdata  = t_we ? t_wdata : shadow[t_addr];
      if (t_we) shadow[t_addr] = t_wdata;
      e_owner  = pick_dma;
      next_ok  = ec + 3;
    end
  end

  // Compare process: every cycle, just after the active edge
  always @(posedge clk) begin
    int unsigned off;
    bit acc, rsp;
    #1;
    off = ec - t_g;
    acc = have_txn && (off == 0);
    rsp = have_txn && (off == 1);
    check1("busy",    busy,        acc || rsp);
    check1("mem_we",  bus.mem_we,  acc && t_we);
    check1("cpu_ack", bus.cpu_ack, rsp && !t_dma);
    check1("dma_ack", bus.dma_ack, rsp && t_dma);
    check1("owner",   owner,       e_owner);
    if (acc || rsp) check8("mem_addr", bus.mem_addr, t_addr);
    if (acc)        check8("mem_wdata", bus.mem_wdata, t_wdata);
    if (rsp)        check8("rdata", bus.rdata, t_rdata);
    if (rst_now) begin
      check8("rst_mem_addr",  bus.mem_addr,  8'h00);
      check8("rst_mem_wdata", bus.mem_wdata, 8'h00);
      check8("rst_rdata",     bus.rdata,     8'h00);
    end
  end

  bit         ack_log [$];
  logic [7:0] last_rd;
  int         we_cycles;

  task automatic run_acks(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.mem_we === 1'b1) we_cycles++;
      if (bus.cpu_ack === 1'b1 || bus.dma_ack === 1'b1) begin
        got++;
        ack_log.push_back(bus.dma_ack === 1'b1);
        last_rd = bus.rdata;
      end
    end
    check_int("ack_within_budget", got, n);
    @(negedge clk);
  endtask

  function automatic logic [15:0] pack_log();
    logic [15:0] v = 16'd0;
    for (int i = 0; i < ack_log.size() && i < 16; i++) v[i] = ack_log[i];
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int waited;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
    end
    mem[8'h10]    = 8'hA5;
    shadow[8'h10] = 8'hA5;

    // Reset with both masters requesting
    reset = 1'b1;
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 8'h20;  bus.cpu_wdata = 8'h00;
    bus.dma_req = 1'b1;  bus.dma_we = 1'b0;  bus.dma_addr = 8'h21;  bus.dma_wdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check1("reset_busy",   busy,        1'b0);
    check1("reset_mem_we", bus.mem_we,  1'b0);
    check1("reset_ack",    bus.cpu_ack | bus.dma_ack, 1'b0);
    reset = 1'b0;

    // First contended grant goes to the CPU, then the bounded-run pattern repeats
    @(posedge clk);
    #1;
    check1("first_grant_busy",  busy,  1'b1);
    check1("first_grant_owner", owner, 1'b0);
    @(negedge clk);
    ack_log.delete();
    run_acks(10, 40);
    check_int("starve_order", int'(pack_log()), int'(16'b0000_0010_0001_0000));
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;

    // CPU read of 0x10; the address changes mid-access and must be ignored
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 8'h10;
    ack_log.delete();
    run_acks(0, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.cpu_addr = 8'hAA;
    run_acks(1, 10);
    check8("cpu_read_a5", last_rd, 8'hA5);
    check_int("cpu_read_owner", int'(ack_log[0]), 0);
    bus.cpu_req = 1'b0;

    // DMA write 0x3C to 0x40, then CPU readback
    bus.dma_req = 1'b1;  bus.dma_we = 1'b1;  bus.dma_addr = 8'h40;  bus.dma_wdata = 8'h3C;
    we_cycles = 0;
    ack_log.delete();
    run_acks(1, 10);
    check_int("dma_we_pulse_len", we_cycles, 1);
    check_int("dma_write_owner", int'(ack_log[0]), 1);
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 8'h40;
    run_acks(1, 10);
    check8("cpu_readback_3c", last_rd, 8'h3C);
    bus.cpu_req = 1'b0;

    // Counter clear: three CPU wins, DMA drops for one sample, then a full run of four
    bus.cpu_addr = 8'h01;  bus.dma_we = 1'b0;  bus.dma_addr = 8'h02;
    bus.cpu_req = 1'b1;    bus.dma_req = 1'b1;
    ack_log.delete();
    run_acks(3, 15);
    bus.dma_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.dma_req = 1'b1;
    run_acks(6, 30);
    check_int("clear_order", int'(pack_log()), int'(16'b0000_0001_0000_0000));
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;

    // Reset during the ACCESS cycle of a CPU write
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b1;  bus.cpu_addr = 8'h55;  bus.cpu_wdata = 8'h77;
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (busy !== 1'b1 && waited < 6);
    check1("midrst_access_we", bus.mem_we, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
    check1("midrst_we_low", bus.mem_we,  1'b0);
    check1("midrst_no_ack", bus.cpu_ack, 1'b0);
    check1("midrst_idle",   busy,        1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    bus.cpu_req = 1'b1;  bus.cpu_we = 1'b0;  bus.cpu_addr = 8'h55;
    run_acks(1, 10);
    check8("write_kept_77", last_rd, 8'h77);
    bus.cpu_req = 1'b0;

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
